hc595_frame_rx: RTL

- Receive end of the 74HC595 serial display link (shcp/stcp/ds) driven by the digital-clock top.
- Oversamples the three link lines on the system clock and rebuilds each latched frame ({digit select, segment pattern}).
- Decodes the segment pattern back to a hex value and stores it per digit.
- Used as a synthesizable link checker and scoreboard source for the display path.

---
 rtl/hc595_frame_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hc595_frame_rx.sv
// hc595_frame_rx: receive end of the 74HC595 serial display link.
// Oversamples shcp/stcp/ds on clk, rebuilds each latched {sel,seg} frame,
// decodes the active-low segment pattern back to a hex value and keeps a
// per-digit shadow of what the display is showing.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   shcp, stcp, ds        raw link lines (asynchronous to clk)
//   frame_data            last latched frame {sel,seg}
//   frame_valid           1-cycle pulse when frame_data updates
//   len_err               1-cycle pulse: latch with bit count != frame width
//   sel_err               1-cycle pulse: sel not exactly one bit low
//   code_err              1-cycle pulse: seg pattern neither in table nor blank
//   digit_val             decoded hex per digit, digit i at [4i+3:4i]
//   digit_dp              dp per digit (1 = lit)
//   digit_on              1 = digit holds a valid decoded value
module hc595_frame_rx #(
  parameter int SEL_BITS    = 6,
  parameter int SEG_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         shcp,
  input  logic                         stcp,
  input  logic                         ds,
  output logic [SEL_BITS+SEG_BITS-1:0] frame_data,
  output logic                         frame_valid,
  output logic                         len_err,
  output logic                         sel_err,
  output logic                         code_err,
  output logic [4*SEL_BITS-1:0]        digit_val,
  output logic [SEL_BITS-1:0]          digit_dp,
  output logic [SEL_BITS-1:0]          digit_on
);

  localparam int N  = SEL_BITS + SEG_BITS;
  localparam int CW = $clog2(N + 2);
  localparam int ZW = $clog2(SEL_BITS + 1);
  localparam int IW = (SEL_BITS > 1) ? $clog2(SEL_BITS) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);

  logic [SYNC_STAGES-1:0] shcp_sync, stcp_sync, ds_sync;
  logic                   shcp_hist, stcp_hist;
  logic                   shcp_rise, stcp_rise, ds_bit;
  logic [N-1:0]           shift_reg;
  logic [CW-1:0]          bit_cnt;

  // Synchronizers plus one history flop per clock line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shcp_sync <= '0;
      stcp_sync <= '0;
      ds_sync   <= '0;
      shcp_hist <= 1'b0;
      stcp_hist <= 1'b0;
    end else begin
      shcp_sync <= {shcp_sync[SYNC_STAGES-2:0], shcp};
      stcp_sync <= {stcp_sync[SYNC_STAGES-2:0], stcp};
      ds_sync   <= {ds_sync[SYNC_STAGES-2:0], ds};
      shcp_hist <= shcp_sync[SYNC_STAGES-1];
      stcp_hist <= stcp_sync[SYNC_STAGES-1];
    end
  end

  // ds comes from the same stage as shcp so data and clock stay aligned.
  assign shcp_rise = shcp_sync[SYNC_STAGES-1] & ~shcp_hist;
  assign stcp_rise = stcp_sync[SYNC_STAGES-1] & ~stcp_hist;
  assign ds_bit    = ds_sync[SYNC_STAGES-1];

  // Shift/latch. On a coincident shcp+stcp edge the latch sees the pre-shift
  // register (like the real 74HC595) and the shifted bit starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
      if (shcp_rise) begin
        shift_reg <= {shift_reg[N-2:0], ds_bit};
      end
      if (stcp_rise) begin
        frame_data  <= shift_reg;
        frame_valid <= 1'b1;
        len_err     <= (bit_cnt != CNT_FULL);
        bit_cnt     <= shcp_rise ? CW'(1) : '0;
      end else if (shcp_rise && bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Returns {hit, code}; dp is masked off before lookup.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h40:   seg_decode = {1'b1, 4'h0};
      7'h79:   seg_decode = {1'b1, 4'h1};
      7'h24:   seg_decode = {1'b1, 4'h2};
      7'h30:   seg_decode = {1'b1, 4'h3};
      7'h19:   seg_decode = {1'b1, 4'h4};
      7'h12:   seg_decode = {1'b1, 4'h5};
      7'h02:   seg_decode = {1'b1, 4'h6};
      7'h78:   seg_decode = {1'b1, 4'h7};
      7'h00:   seg_decode = {1'b1, 4'h8};
      7'h10:   seg_decode = {1'b1, 4'h9};
      7'h08:   seg_decode = {1'b1, 4'hA};
      7'h03:   seg_decode = {1'b1, 4'hB};
      7'h46:   seg_decode = {1'b1, 4'hC};
      7'h21:   seg_decode = {1'b1, 4'hD};
      7'h06:   seg_decode = {1'b1, 4'hE};
      7'h0E:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'b0_0000;
    endcase
  endfunction

  logic [SEL_BITS-1:0] dec_sel;
  logic [SEG_BITS-1:0] dec_seg;
  logic [ZW-1:0]       sel_zeros;
  logic [IW-1:0]       sel_idx;
  logic [4:0]          dec_res;

  assign dec_sel = frame_data[N-1:SEG_BITS];
  assign dec_seg = frame_data[SEG_BITS-1:0];
  assign dec_res = seg_decode(dec_seg[6:0]);

  always_comb begin
    sel_zeros = '0;
    sel_idx   = '0;
    for (int i = 0; i < SEL_BITS; i++) begin
      if (!dec_sel[i]) begin
        sel_zeros = sel_zeros + ZW'(1);
        sel_idx   = IW'(i);
      end
    end
  end

  // frame_data is stable while frame_valid is high, so decoding on that
  // cycle handles back-to-back latches in order without a queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      code_err  <= 1'b0;
      digit_val <= '0;
      digit_dp  <= '0;
      digit_on  <= '0;
    end else begin
      sel_err  <= 1'b0;
      code_err <= 1'b0;
      if (frame_valid) begin
        if (sel_zeros != ZW'(1)) begin
          sel_err <= 1'b1;
        end else if (dec_seg[6:0] == 7'h7F) begin
          digit_on[sel_idx] <= 1'b0;
        end else if (dec_res[4]) begin
          digit_val[int'(sel_idx)*4 +: 4] <= dec_res[3:0];
          digit_on[sel_idx]               <= 1'b1;
          digit_dp[sel_idx]               <= ~dec_seg[7];
        end else begin
          code_err <= 1'b1;
        end
      end
    end
  end

endmodule
